// File: rtl/conv_fitobf16_vec.sv
// Multi-lane fixed-point to bfloat16 converter with a shared E8M0 scale. It has three pipeline stages and a valid/ready interface on each side.
// Optional: define CONV_FITOBF16_VEC_SAT_EN to clamp out-of-range exponents; without it the exponent wraps to 8 bits.
module conv_fitobf16_vec #(
    parameter int bit_width = 16,
    parameter int in_bias   = 0,
    parameter int lanes     = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [lanes*bit_width-1:0] i_fi_num,
    input  logic [7:0]                 i_scale,
    input  logic                       i_rnd_mode,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [lanes*16-1:0]        o_bf16
);

    localparam int LZW      = $clog2(bit_width);
    localparam int EXW      = bit_width + 8;
    localparam int EOFF_INT = bit_width - 1 - in_bias;
`ifdef CONV_FITOBF16_VEC_SAT_EN
    localparam int EW = 11;
`else
    localparam int EW = 8;
`endif

    logic s1_v_q, s2_v_q, s3_v_q;
    logic s1_en, s2_en, s3_en;

    logic [lanes-1:0]     s1_sign_d, s1_sign_q;
    logic [bit_width-1:0] s1_mag_d [lanes];
    logic [bit_width-1:0] s1_mag_q [lanes];
    logic [LZW-1:0]       s1_lz_d [lanes];
    logic [LZW-1:0]       s1_lz_q [lanes];
    logic [7:0]           s1_scale_q;
    logic                 s1_rnd_q;

    logic [lanes-1:0]     s2_lead, s2_inc;
    logic [EXW-1:0]       s2_ext [lanes];
    logic [7:0]           s2_sum [lanes];
    logic [lanes-1:0]     s2_sign_q, s2_zero_q, s2_carry_q;
    logic [6:0]           s2_mant_q [lanes];
    logic [LZW-1:0]       s2_lz_q [lanes];
    logic [7:0]           s2_scale_q;

    logic signed [EW-1:0] s3_e [lanes];
    logic [lanes*16-1:0]  s3_d, s3_q;

    // A stage may load when its successor is empty or draining, so bubbles collapse under stall.
    assign s3_en   = !s3_v_q || i_ready;
    assign s2_en   = !s2_v_q || s3_en;
    assign s1_en   = !s1_v_q || s2_en;
    assign o_ready = s1_en;
    assign o_valid = s3_v_q;
    assign o_bf16  = s3_q;

    always_comb begin
        for (int k = 0; k < lanes; k++) begin
            s1_sign_d[k] = i_fi_num[k*bit_width + bit_width - 1];
            s1_mag_d[k]  = s1_sign_d[k] ? (~i_fi_num[k*bit_width +: bit_width] + bit_width'(1))
                                        : i_fi_num[k*bit_width +: bit_width];
            s1_lz_d[k]   = '0;
            for (int i = 0; i < bit_width; i++) begin
                if (s1_mag_d[k][i]) s1_lz_d[k] = LZW'(bit_width - 1 - i);
            end
        end
    end

    // After the shift the leading one falls out as s2_lead. For a nonzero magnitude it is always 1, so it also serves as the zero flag.
    always_comb begin
        for (int k = 0; k < lanes; k++) begin
            {s2_lead[k], s2_ext[k]} = {s1_mag_q[k], 9'b0} << s1_lz_q[k];
            s2_inc[k] = !s1_rnd_q && s2_ext[k][bit_width]
                        && (s2_ext[k][bit_width+1] || (|s2_ext[k][bit_width-1:0]));
            s2_sum[k] = {1'b0, s2_ext[k][EXW-1 -: 7]} + {7'b0, s2_inc[k]};
        end
    end

    // The +127 exponent bias and the -127 scale bias cancel, so the scale byte is added directly to form the biased exponent.
    always_comb begin
        s3_d = '0;
        for (int k = 0; k < lanes; k++) begin
            s3_e[k] = EW'(EOFF_INT) - EW'(s2_lz_q[k]) + EW'(s2_carry_q[k]) + EW'(s2_scale_q);
            if (s2_scale_q == 8'hFF)
                s3_d[k*16 +: 16] = 16'h7FC0;
            else if (s2_zero_q[k])
                s3_d[k*16 +: 16] = 16'h0000;
`ifdef CONV_FITOBF16_VEC_SAT_EN
            else if (s3_e[k] >= 11'sd255)
                s3_d[k*16 +: 16] = {s2_sign_q[k], 15'h7F7F};
            else if (s3_e[k] <= 11'sd0)
                s3_d[k*16 +: 16] = {s2_sign_q[k], 15'h0000};
`endif
            else
                s3_d[k*16 +: 16] = {s2_sign_q[k], s3_e[k][7:0], s2_mant_q[k]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            s3_v_q <= 1'b0;
            s3_q   <= '0;
        end else begin
            if (s1_en) s1_v_q <= i_valid;
            if (s2_en) s2_v_q <= s1_v_q;
            if (s3_en) begin
                s3_v_q <= s2_v_q;
                s3_q   <= s3_d;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (s1_en) begin
            s1_sign_q  <= s1_sign_d;
            s1_mag_q   <= s1_mag_d;
            s1_lz_q    <= s1_lz_d;
            s1_scale_q <= i_scale;
            s1_rnd_q   <= i_rnd_mode;
        end
        if (s2_en) begin
            s2_sign_q  <= s1_sign_q;
            s2_scale_q <= s1_scale_q;
            s2_lz_q    <= s1_lz_q;
            for (int k = 0; k < lanes; k++) begin
                s2_zero_q[k]  <= !s2_lead[k];
                s2_mant_q[k]  <= s2_sum[k][6:0];
                s2_carry_q[k] <= s2_sum[k][7];
            end
        end
    end

endmodule

// File: tb/tb_conv_fitobf16_vec.sv
// Directed bench for conv_fitobf16_vec. The expected values are hand-computed, and any beat leaving the main instance is checked against a queue of those values.
module tb_conv_fitobf16_vec;

    logic        clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_rdy;
    logic [63:0] fi_num = '0;
    logic [7:0]  scale = 8'h7F;
    logic        rnd_mode = 1'b0;
    logic        out_valid;
    logic        out_rdy = 1'b1;
    logic [63:0] bf16;

    logic        v6 = 1'b0;
    logic        rdy6;
    logic [5:0]  fi6 = '0;
    logic [7:0]  scale6 = 8'h7F;
    logic        ov6;
    logic [15:0] bf6;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_push = 0;
    int          n_rx = 0;
    logic [63:0] exp_q [$];
    logic        held_pending = 1'b0;
    logic [63:0] held_val = '0;

`ifdef CONV_FITOBF16_VEC_SAT_EN
    localparam logic [15:0] OVF_EXP = 16'h7F7F;
`else
    localparam logic [15:0] OVF_EXP = 16'h0600;
`endif
    localparam logic [15:0] SMALL_BF [10] = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080, 16'h40A0,
                                              16'h40C0, 16'h40E0, 16'h4100, 16'h4110, 16'h4120};

    conv_fitobf16_vec dut (
        .i_clk      (clk_sys),
        .i_rst      (rst),
        .i_valid    (in_valid),
        .o_ready    (in_rdy),
        .i_fi_num   (fi_num),
        .i_scale    (scale),
        .i_rnd_mode (rnd_mode),
        .o_valid    (out_valid),
        .i_ready    (out_rdy),
        .o_bf16     (bf16)
    );

    conv_fitobf16_vec #(.bit_width(6), .in_bias(0), .lanes(1)) dut6 (
        .i_clk      (clk_sys),
        .i_rst      (rst),
        .i_valid    (v6),
        .o_ready    (rdy6),
        .i_fi_num   (fi6),
        .i_scale    (scale6),
        .i_rnd_mode (1'b0),
        .o_valid    (ov6),
        .i_ready    (1'b1),
        .o_bf16     (bf6)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [63:0] data, input logic [7:0] sc, input logic rm,
                        input logic [63:0] exp);
        int   waits = 0;
        logic acc = 1'b0;
        @(negedge clk_sys);
        in_valid = 1'b1;
        fi_num   = data;
        scale    = sc;
        rnd_mode = rm;
        while (!acc) begin
            #1 acc = in_rdy;
            @(posedge clk_sys);
            if (!acc) begin
                waits++;
                if (waits > 40) begin
                    check_val("accept_timeout", 64'(waits), 64'd0);
                    break;
                end
                @(negedge clk_sys);
            end
        end
        if (acc) begin
            exp_q.push_back(exp);
            n_push++;
        end
    endtask

    task automatic idle();
        @(negedge clk_sys);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk_sys);
            n++;
        end
        #3;
        check_val("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Output monitor: checks every delivered beat and that a stalled output holds.
    always begin
        @(negedge clk_sys);
        #2;
        if (rst) begin
            held_pending = 1'b0;
        end else begin
            if (held_pending) begin
                check_val("hold_data", bf16, held_val);
                check_val("hold_valid", 64'(out_valid), 64'd1);
            end
            held_pending = out_valid && !out_rdy;
            held_val     = bf16;
            if (out_valid && out_rdy) begin
                n_rx++;
                if (exp_q.size() == 0)
                    check_val("unexpected_beat", 64'(n_rx), 64'(n_push));
                else
                    check_val($sformatf("beat%0d", n_rx), bf16, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int rx_before;

        repeat (3) @(negedge clk_sys);
        #2;
        check_val("rst_o_valid", 64'(out_valid), 64'd0);
        check_val("rst_o_ready", 64'(in_rdy), 64'd1);
        check_val("rst_o_bf16", bf16, 64'd0);
        @(negedge clk_sys);
        rst = 1'b0;

        // Basic lanes and latency.
        send({16'h8000, 16'h0000, 16'hFFFF, 16'h0001}, 8'h7F, 1'b0,
             {16'hC700, 16'h0000, 16'hBF80, 16'h3F80});
        idle();
        #2 check_val("lat_c1", 64'(out_valid), 64'd0);
        @(negedge clk_sys);
        #2 check_val("lat_c2", 64'(out_valid), 64'd0);
        @(negedge clk_sys);
        #2 check_val("lat_c3", 64'(out_valid), 64'd1);
        drain();

        // Rounding: RNE, then truncate, then the scale and NaN cases.
        send({16'hFE7D, 16'h01FF, 16'h0183, 16'h0181}, 8'h7F, 1'b0,
             {16'hC3C2, 16'h4400, 16'h43C2, 16'h43C0});
        send({16'hFE7D, 16'h01FF, 16'h0183, 16'h0181}, 8'h7F, 1'b1,
             {16'hC3C1, 16'h43FF, 16'h43C1, 16'h43C0});
        send({16'hFFFF, 16'h0000, 16'h4000, 16'h0001}, 8'hFE, 1'b0,
             {16'hFF00, 16'h0000, OVF_EXP, 16'h7F00});
        send({16'h0003, 16'h0002, 16'h0001, 16'hFFFF}, 8'h00, 1'b0,
             {16'h00C0, 16'h0080, 16'h0000, 16'h8000});
        send({16'h1234, 16'h8000, 16'h0000, 16'h0001}, 8'hFF, 1'b0,
             {16'h7FC0, 16'h7FC0, 16'h7FC0, 16'h7FC0});
        idle();
        drain();

        // The 6-bit, single-lane instance.
        @(negedge clk_sys);
        v6 = 1'b1;
        fi6 = 6'h1F;
        @(negedge clk_sys);
        fi6 = 6'h20;
        @(negedge clk_sys);
        v6 = 1'b0;
        @(negedge clk_sys);
        #2;
        check_val("bw6_v0", 64'(ov6), 64'd1);
        check_val("bw6_d0", 64'(bf6), 64'h41F8);
        @(negedge clk_sys);
        #2;
        check_val("bw6_v1", 64'(ov6), 64'd1);
        check_val("bw6_d1", 64'(bf6), 64'hC200);

        // Backpressure on a 10-beat stream.
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send({16'h0000, 16'((i + 1) << 4), 16'(-(i + 1)), 16'(i + 1)}, 8'h7F, 1'b0,
                         {16'h0000, SMALL_BF[i] + 16'h0200, SMALL_BF[i] | 16'h8000, SMALL_BF[i]});
                end
                idle();
            end
            begin
                repeat (5) @(negedge clk_sys);
                out_rdy = 1'b0;
                for (int j = 0; j < 5; j++) begin
                    #2;
                    if (j == 2) check_val("bp_o_ready_full", 64'(in_rdy), 64'd0);
                    @(negedge clk_sys);
                end
                out_rdy = 1'b1;
            end
        join
        drain();
        check_val("bp_count", 64'(n_rx), 64'(n_push));

        // Reset with three beats in flight.
        @(negedge clk_sys);
        out_rdy = 1'b0;
        send(64'h0001_0001_0001_0001, 8'h7F, 1'b0, 64'h3F80_3F80_3F80_3F80);
        send(64'h0002_0002_0002_0002, 8'h7F, 1'b0, 64'h4000_4000_4000_4000);
        send(64'h0003_0003_0003_0003, 8'h7F, 1'b0, 64'h4040_4040_4040_4040);
        idle();
        rst = 1'b1;
        @(negedge clk_sys);
        rst = 1'b0;
        #2;
        check_val("mid_rst_o_valid", 64'(out_valid), 64'd0);
        check_val("mid_rst_o_ready", 64'(in_rdy), 64'd1);
        check_val("mid_rst_o_bf16", bf16, 64'd0);
        exp_q.delete();
        n_push    = n_rx;
        rx_before = n_rx;
        out_rdy   = 1'b1;
        repeat (8) @(negedge clk_sys);
        #3;
        check_val("no_stale_beat", 64'(n_rx), 64'(rx_before));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv_fitobf16_vec.md
# conv_fitobf16_vec

Pipelined, multi-lane converter from signed two's-complement fixed-point to bfloat16 with MX-style shared E8M0 scale. Each beat carries `lanes` fixed-point elements plus one shared scale; all lanes convert in parallel and emit one bf16 vector per beat. It sits between MX block decode (fixed-point element lanes) and bf16 datapaths, behind a valid/ready stream interface.

## Interface
- `bit_width`, 16, fixed-point element width; legal 2..32.
- `in_bias`, 0, binary point position (value = integer · 2^-in_bias); legal 0..bit_width-1.
- `lanes`, 4, elements per beat; legal 1..32.
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  input beat valid.
- `o_ready`  out  1  converter can accept a beat.
- `i_fi_num`  in  lanes·bit_width  elements; lane k at bits [k·bit_width +: bit_width].
- `i_scale`  in  8  shared E8M0 scale, bias 127; 0xFF = NaN.
- `i_rnd_mode`  in  1  0 = round-nearest-even, 1 = truncate (toward zero).
- `o_valid`  out  1  output beat valid.
- `i_ready`  in  1  downstream accepts beat.
- `o_bf16`  out  lanes·16  results; lane k at bits [k·16 +: 16].

## Operation
- Per lane: sign = MSB; magnitude = |x| as unsigned bit_width (0x8000 at 16 bits → magnitude 32768, no overflow).
- lz = leading zeros of magnitude; align left by lz. Mantissa = 7 bits below leading one, zero-padded on right if bit_width < 8; R = next bit, S = OR of remaining bits (0 if absent).
- RNE: increment when R & (LSB | S). Truncate: never increment. Increment carry-out → mantissa 0, exponent +1.
- Unbiased exponent e = bit_width-1 - lz + carry - in_bias + (i_scale - 127), computed signed 11-bit; biased E = e + 127.
- Zero input → ±0 field: sign 0, exp 0, mant 0 (0x0000).
- i_scale = 0xFF → every lane 0x7FC0 regardless of data.
- E in 1..254 → {sign, E[7:0], mant}. Out-of-range handling per Configuration.
- i_rnd_mode and i_scale are sampled with the beat and travel with it.

## Timing
- Three stages: S1 sign/magnitude/lz; S2 align/round; S3 exponent/pack/range check. Latency 3 cycles from accepted beat to o_valid; throughput 1 beat/cycle.
- Transfer on i_valid & o_ready (input) and o_valid & i_ready (output).
- Stage n advances when stage n+1 empty or advancing; o_ready = S1 empty or S1 advancing. Bubbles collapse under stall.
- While o_valid & !i_ready: o_bf16 held stable, o_valid held high.
- Pipeline full and i_ready low → o_ready low same cycle (combinational from i_ready permitted).
- Reset: all stage valids 0, o_valid = 0, o_bf16 = 0, o_ready = 1 in cycle after i_rst sampled high; in-flight beats discarded. Reset mid-stream drops everything.

## Configuration
- `CONV_FITOBF16_VEC_SAT_EN` defined: E ≥ 255 → ±max finite (0x7F7F / 0xFF7F); E ≤ 0 → signed zero (sign kept, exp 0, mant 0).
- Undefined: E wraps to low 8 bits, no clamp (legacy-compatible); S3 range-check logic absent.

## Test plan
Defaults (16-bit, in_bias 0, 4 lanes), i_scale 0x7F, RNE unless noted.
- Lanes {1, 0xFFFF, 0, 0x8000} → {0x3F80, 0xBF80, 0x0000, 0xC700}, o_valid exactly 3 cycles after accept.
- Rounding: 0x0181 → 0x43C0 (tie, even); 0x0183 → 0x43C2 RNE, 0x43C1 truncate; 0x01FF → 0x4400 (mantissa carry).
- Scale: 1 with i_scale 0xFE → 0x7F00; 0x4000 with 0xFE → 0x7F7F (SAT_EN) / 0x0600 (undefined); 0xFFFF with 0x00 → 0x8000 SAT_EN; any data with 0xFF → 0x7FC0 all lanes.
- Backpressure: stream 10 beats, i_ready low 5 cycles mid-stream → no loss/duplication, order kept, o_bf16 stable while stalled, o_ready low once 3 stages full.
- Reset with 3 beats in flight → o_valid 0 next cycle, o_ready 1; no stale beat after reset.
- bit_width 6, lanes 1: 0x1F → 0x41F8; 0x20 → 0xC200.
